// File: rtl/uart_msg_tx.sv
// Message-streaming UART transmitter: walks ROM addresses 0..MSG_LEN-1 and sends each byte 8N1.
// Optional even parity bit when UART_MSG_TX_PARITY_EN is defined (8E1 frames).
module uart_msg_tx #(
   parameter int unsigned CLKS_PER_BIT = 1250,
   parameter int unsigned MSG_LEN      = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   output logic [4:0] add,
   input  logic [7:0] rom_byte,
   output logic       tx,
   output logic       busy,
   output logic       done
);

   localparam int unsigned     BaudW    = $clog2(CLKS_PER_BIT);
   localparam logic [BaudW-1:0] BaudLast = BaudW'(CLKS_PER_BIT - 1);
   localparam logic [4:0]      AddLast  = 5'(MSG_LEN - 1);

`ifdef UART_MSG_TX_PARITY_EN
   typedef enum logic [2:0] {StIdle, StFetch, StLoad, StStart, StData, StStop, StParity} state_e;
`else
   typedef enum logic [2:0] {StIdle, StFetch, StLoad, StStart, StData, StStop} state_e;
`endif

   state_e           state_q;
   logic [BaudW-1:0] baud_q;
   logic [2:0]       bit_q;
   logic [7:0]       shift_q;
   logic             baud_tick;
`ifdef UART_MSG_TX_PARITY_EN
   logic             parity_q;
`endif

   assign baud_tick = (baud_q == BaudLast);

   // tx is updated on the same edge as the state change so the line is aligned with each bit slot.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         baud_q  <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         add     <= '0;
         tx      <= 1'b1;
         busy    <= 1'b0;
         done    <= 1'b0;
`ifdef UART_MSG_TX_PARITY_EN
         parity_q <= 1'b0;
`endif
      end else begin
         done <= 1'b0;
         case (state_q)
            StIdle: begin
               tx   <= 1'b1;
               busy <= 1'b0;
               add  <= '0;
               if (start) begin
                  busy    <= 1'b1;
                  state_q <= StFetch;
               end
            end
            StFetch: state_q <= StLoad;
            StLoad: begin
               shift_q <= rom_byte;
`ifdef UART_MSG_TX_PARITY_EN
               parity_q <= ^rom_byte;
`endif
               baud_q  <= '0;
               tx      <= 1'b0;
               state_q <= StStart;
            end
            StStart: begin
               if (baud_tick) begin
                  baud_q  <= '0;
                  bit_q   <= '0;
                  tx      <= shift_q[0];
                  state_q <= StData;
               end else begin
                  baud_q <= baud_q + BaudW'(1);
               end
            end
            StData: begin
               if (baud_tick) begin
                  baud_q  <= '0;
                  shift_q <= shift_q >> 1;
                  if (bit_q == 3'd7) begin
`ifdef UART_MSG_TX_PARITY_EN
                     tx      <= parity_q;
                     state_q <= StParity;
`else
                     tx      <= 1'b1;
                     state_q <= StStop;
`endif
                  end else begin
                     bit_q <= bit_q + 3'd1;
                     tx    <= shift_q[1];
                  end
               end else begin
                  baud_q <= baud_q + BaudW'(1);
               end
            end
`ifdef UART_MSG_TX_PARITY_EN
            StParity: begin
               if (baud_tick) begin
                  baud_q  <= '0;
                  tx      <= 1'b1;
                  state_q <= StStop;
               end else begin
                  baud_q <= baud_q + BaudW'(1);
               end
            end
`endif
            StStop: begin
               if (baud_tick) begin
                  baud_q <= '0;
                  if (add == AddLast) begin
                     add     <= '0;
                     done    <= 1'b1;
                     busy    <= 1'b0;
                     state_q <= StIdle;
                  end else begin
                     add     <= add + 5'd1;
                     state_q <= StFetch;
                  end
               end else begin
                  baud_q <= baud_q + BaudW'(1);
               end
            end
            default: begin
               tx      <= 1'b1;
               busy    <= 1'b0;
               state_q <= StIdle;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_msg_tx.sv
// Self-checking bench for uart_msg_tx: registered ROM model plus a per-cycle line model of each frame.
// Honours UART_MSG_TX_PARITY_EN the same way as the design.
module tb_uart_msg_tx;

   localparam int C = 4;
   localparam int L = 16;
`ifdef UART_MSG_TX_PARITY_EN
   localparam int F = 11 * C + 2;
`else
   localparam int F = 10 * C + 2;
`endif
   localparam int TOTAL = L * F;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start;
   logic [4:0] add;
   logic [7:0] rom_byte;
   logic       tx;
   logic       busy;
   logic       done;
   logic [7:0] rom [32];

   int n_tests = 0;
   int n_fail  = 0;

   uart_msg_tx #(
      .CLKS_PER_BIT(C),
      .MSG_LEN     (L)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (start),
      .add     (add),
      .rom_byte(rom_byte),
      .tx      (tx),
      .busy    (busy),
      .done    (done)
   );

   always #5 clk = ~clk;

   // Registered ROM: data for an address appears one edge after it is presented.
   always @(posedge clk) rom_byte <= rom[add];

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Line level at a cycle offset within one byte slot (gap, start, data LSB-first, [parity], stop).
   function automatic logic line_at(input logic [7:0] b, input int off);
      int slot;
      if (off < 2) return 1'b1;
      slot = (off - 2) / C;
      if (slot == 0) return 1'b0;
      if (slot <= 8) return b[slot-1];
`ifdef UART_MSG_TX_PARITY_EN
      if (slot == 9) return ^b;
`endif
      return 1'b1;
   endfunction

   function automatic logic [63:0] exp_frame(input logic [7:0] b);
      logic [63:0] v = '0;
      for (int j = 0; j < F; j++) v[j] = line_at(b, j);
      return v;
   endfunction

   // k=0 is the first cycle after start is accepted; poke_k pulses start mid-message,
   // hold keeps start high throughout, pre means start was already accepted.
   task automatic run_msg(input int poke_k, input bit hold, input bit pre);
      logic [63:0] obs = '0;
      bit add_ok  = 1'b1;
      bit busy_ok = 1'b1;
      int n_done  = 0;
      int b, off;
      if (!pre) begin
         start = 1'b1;
         @(negedge clk);
      end
      for (int k = 0; k <= TOTAL; k++) begin
         if (k < TOTAL) begin
            b   = k / F;
            off = k % F;
            obs[off] = tx;
            if (add !== 5'(b)) add_ok = 1'b0;
            if (busy !== 1'b1) busy_ok = 1'b0;
            if (done === 1'b1) n_done++;
            if (off == F - 1) begin
               check_eq($sformatf("frame%0d", b), obs, exp_frame(rom[b]));
               check_eq($sformatf("add_stable%0d", b), 64'(add_ok), 64'd1);
               check_eq($sformatf("busy%0d", b), 64'(busy_ok), 64'd1);
               obs     = '0;
               add_ok  = 1'b1;
               busy_ok = 1'b1;
            end
         end else begin
            check_eq("done_at_end", 64'(done), 64'd1);
            check_eq("busy_end", 64'(busy), 64'd0);
            check_eq("add_end", 64'(add), 64'd0);
            check_eq("tx_end", 64'(tx), 64'd1);
            check_eq("early_done", 64'(n_done), 64'd0);
         end
         start = hold || (k == poke_k);
         @(negedge clk);
      end
      check_eq("done_pulse", 64'(done), 64'd0);
   endtask

   initial begin
      string s = "KISHAN   PATEL\n\r";
      int    cut;
      bit    ok;
      for (int i = 0; i < 32; i++) rom[i] = (i < L) ? s[i] : 8'h00;
      rst_n = 1'b0;
      start = 1'b0;
      repeat (3) @(negedge clk);
      check_eq("rst_tx", 64'(tx), 64'd1);
      check_eq("rst_busy", 64'(busy), 64'd0);
      check_eq("rst_done", 64'(done), 64'd0);
      check_eq("rst_add", 64'(add), 64'd0);
      rst_n = 1'b1;
      ok = 1'b1;
      repeat (50) begin
         @(negedge clk);
         if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || add !== 5'd0) ok = 1'b0;
      end
      check_eq("idle_hold", 64'(ok), 64'd1);

      run_msg(-1, 1'b0, 1'b0);
      run_msg(5 * F + int'($urandom_range(0, F - 1)), 1'b0, 1'b0);

      // Abort during the data bits of byte 3.
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      cut = 3 * F + 2 + C + int'($urandom_range(0, 8 * C - 1));
      repeat (cut) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check_eq("abort_tx", 64'(tx), 64'd1);
      check_eq("abort_busy", 64'(busy), 64'd0);
      check_eq("abort_add", 64'(add), 64'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      ok = 1'b1;
      repeat (10) begin
         @(negedge clk);
         if (tx !== 1'b1 || busy !== 1'b0) ok = 1'b0;
      end
      check_eq("abort_quiet", 64'(ok), 64'd1);
      run_msg(-1, 1'b0, 1'b0);

      run_msg(-1, 1'b1, 1'b0);
      run_msg(-1, 1'b0, 1'b1);

      repeat (3) begin
         for (int i = 0; i < L; i++) rom[i] = 8'($urandom);
         run_msg(int'($urandom_range(0, TOTAL - 1)), 1'b0, 1'b0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
